// File: rtl/disk_track_loader.sv
// disk_track_loader: streams whole floppy tracks between hps_io SD blocks and per-drive track buffers.
// Optional write-back of dirty tracks (with flush) is built when DTL_WRITEBACK_EN is defined.
module disk_track_loader #(
    parameter int NUM_DRIVES     = 2,
    parameter int SECS_PER_TRACK = 13,
    parameter int TRACK_W        = 6,
    localparam int DRV_W         = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1,
    localparam int SEC_W         = 4
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [NUM_DRIVES*TRACK_W-1:0] track,
    input  logic [NUM_DRIVES-1:0]         disk_we,
    input  logic [NUM_DRIVES-1:0]         img_mounted,
    input  logic [NUM_DRIVES-1:0]         img_nonempty,
    input  logic [NUM_DRIVES-1:0]         img_readonly,
    input  logic                          flush,
    output logic [NUM_DRIVES*32-1:0]      sd_lba,
    output logic [NUM_DRIVES-1:0]         sd_rd,
    output logic [NUM_DRIVES-1:0]         sd_wr,
    input  logic [NUM_DRIVES-1:0]         sd_ack,
    output logic [DRV_W-1:0]              buf_drv,
    output logic [SEC_W-1:0]              buf_sec,
    output logic                          cpu_wait,
    output logic                          busy
);
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECS_PER_TRACK - 1);

    typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

    state_t                  state, state_nx;
    logic [DRV_W-1:0]        svc, svc_nx, last, last_nx, pick;
    logic [TRACK_W-1:0]      tgt, tgt_nx;
    logic [31:0]             lba, lba_nx;
    logic [SEC_W-1:0]        sec, sec_nx;
    logic                    req, req_nx, wait_r, wait_nx, abort, abort_nx, fo, fo_nx, found;
    logic [NUM_DRIVES-1:0]   ack_q, need;
    logic [NUM_DRIVES-1:0]   loaded, loaded_nx, dirty, dirty_nx, mounted, mounted_nx, ro, ro_nx;
    logic [TRACK_W-1:0]      cur_track [NUM_DRIVES];
    logic [TRACK_W-1:0]      cur_nx [NUM_DRIVES];
    logic [TRACK_W-1:0]      trk [NUM_DRIVES];
    logic                    ack_rise, ack_fall, mnt_svc, abort_now;

    function automatic logic [31:0] blk(input logic [TRACK_W-1:0] t);
        return 32'(t) * 32'(SECS_PER_TRACK);
    endfunction

    assign ack_rise  = sd_ack[svc] & ~ack_q[svc];
    assign ack_fall  = ~sd_ack[svc] & ack_q[svc];
    assign mnt_svc   = img_mounted[svc];
    assign abort_now = abort | mnt_svc;
    assign buf_drv   = svc;
    assign buf_sec   = sec;
    assign cpu_wait  = wait_r;
    assign busy      = (state != IDLE);

`ifndef DTL_WRITEBACK_EN
    logic unused_wb;
    assign unused_wb = ^{disk_we, ro};
`endif

    // Per-drive service demand and round-robin pick starting after the last drive served.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int d = 0; d < NUM_DRIVES; d++) begin
            trk[d]  = track[d*TRACK_W +: TRACK_W];
            need[d] = mounted[d] & ~img_mounted[d] &
                      (~loaded[d] | (trk[d] != cur_track[d]) | (flush & dirty[d]));
        end
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (!found && need[(int'(last) + 1 + i) % NUM_DRIVES]) begin
                found = 1'b1;
                pick  = DRV_W'((int'(last) + 1 + i) % NUM_DRIVES);
            end
        end
    end

    // Next-state logic: per-drive mount/dirty bookkeeping followed by the block-transfer FSM.
    always_comb begin
        state_nx   = state;
        svc_nx     = svc;
        last_nx    = last;
        tgt_nx     = tgt;
        lba_nx     = lba;
        sec_nx     = sec;
        req_nx     = req;
        wait_nx    = wait_r;
        abort_nx   = abort;
        fo_nx      = fo;
        cur_nx     = cur_track;
        loaded_nx  = loaded;
        dirty_nx   = dirty;
        mounted_nx = mounted;
        ro_nx      = ro;
        for (int d = 0; d < NUM_DRIVES; d++) begin
            if (img_mounted[d]) begin
                mounted_nx[d] = img_nonempty[d];
                ro_nx[d]      = img_readonly[d];
                loaded_nx[d]  = 1'b0;
                dirty_nx[d]   = 1'b0;
            end
`ifdef DTL_WRITEBACK_EN
            else if (disk_we[d] & mounted[d] & ~ro[d] & ~(busy && svc == DRV_W'(d)))
                dirty_nx[d] = 1'b1;
`endif
        end
        case (state)
            IDLE: begin
                if (found) begin
                    svc_nx   = pick;
                    last_nx  = pick;
                    tgt_nx   = trk[pick];
                    sec_nx   = '0;
                    req_nx   = 1'b1;
                    wait_nx  = 1'b1;
                    abort_nx = 1'b0;
                    fo_nx    = loaded[pick] & (trk[pick] == cur_track[pick]);
                    state_nx = (dirty[pick] & loaded[pick]) ? WB : RD;
                    lba_nx   = (dirty[pick] & loaded[pick]) ? blk(cur_track[pick]) : blk(trk[pick]);
                end
            end
            WB, RD: begin
                if (mnt_svc) abort_nx = 1'b1;
                if (ack_rise) req_nx = 1'b0;
                if (ack_fall) begin
                    if (abort_now) begin
                        state_nx = IDLE;
                        wait_nx  = 1'b0;
                    end else if (sec != LAST_SEC) begin
                        sec_nx = sec + SEC_W'(1);
                        lba_nx = lba + 32'd1;
                        req_nx = 1'b1;
                    end else if (state == WB) begin
                        dirty_nx[svc] = 1'b0;
                        state_nx      = fo ? DONE : RD;
                        wait_nx       = ~fo;
                        req_nx        = ~fo;
                        sec_nx        = '0;
                        lba_nx        = fo ? lba : blk(tgt);
                    end else begin
                        cur_nx[svc]    = tgt;
                        loaded_nx[svc] = 1'b1;
                        state_nx       = DONE;
                        wait_nx        = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered state; every output derives from these flops.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= IDLE;
            svc       <= '0;
            last      <= '0;
            tgt       <= '0;
            lba       <= '0;
            sec       <= '0;
            req       <= 1'b0;
            wait_r    <= 1'b0;
            abort     <= 1'b0;
            fo        <= 1'b0;
            ack_q     <= '0;
            cur_track <= '{default: '0};
            loaded    <= '0;
            dirty     <= '0;
            mounted   <= '0;
            ro        <= '0;
        end else begin
            state     <= state_nx;
            svc       <= svc_nx;
            last      <= last_nx;
            tgt       <= tgt_nx;
            lba       <= lba_nx;
            sec       <= sec_nx;
            req       <= req_nx;
            wait_r    <= wait_nx;
            abort     <= abort_nx;
            fo        <= fo_nx;
            ack_q     <= sd_ack;
            cur_track <= cur_nx;
            loaded    <= loaded_nx;
            dirty     <= dirty_nx;
            mounted   <= mounted_nx;
            ro        <= ro_nx;
        end
    end

    // Request and address lanes: only the drive in service sees a nonzero lane.
    always_comb begin
        for (int d = 0; d < NUM_DRIVES; d++) begin
            sd_lba[d*32 +: 32] = (svc == DRV_W'(d)) ? lba : 32'd0;
            sd_rd[d]           = (state == RD) && req && (svc == DRV_W'(d));
`ifdef DTL_WRITEBACK_EN
            sd_wr[d]           = (state == WB) && req && (svc == DRV_W'(d));
`else
            sd_wr[d]           = 1'b0;
`endif
        end
    end
endmodule
